// File: rtl/onehot_alu_pkg.sv
// Shared types and constants for the handshaked one-hot ALU pipeline.
package onehot_alu_pkg;

  typedef enum logic [2:0] {
    OP_ACC  = 3'd0,
    OP_ADD  = 3'd1,
    OP_ABS  = 3'd2,
    OP_SMAX = 3'd3,
    OP_SMIN = 3'd4,
    OP_UMIN = 3'd5,
    OP_UMAX = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Hex digit segments, bit0=a .. bit6=g, active high.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/onehot_alu_pipe_encoder.sv
// One-hot to binary encoder; highest set bit wins, flags anything not exactly one-hot.
module onehot_encoder #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] bin_o,
  output logic         bad_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < N; i++)
      if (onehot_i[i]) bin_o = W'(i);
  end

  assign bad_o = ($countones(onehot_i) != 1);

endmodule

// File: rtl/onehot_alu_pipe.sv
// Registered one-hot ALU: IDLE captures operands, EXEC computes, HOLD presents the result.
module onehot_alu_pipe
  import onehot_alu_pkg::*;
#(
  parameter int N       = 16,
  parameter bit ABS_SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  input  logic [2:0]   opc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         overflow,
  output logic         err,
  output logic [6:0]   seg
);

  localparam int W = $clog2(N);

  state_e         state_q, state_d;
  logic [W-1:0]   a_bin, b_bin;
  logic           a_bad, b_bad;
  logic [W-1:0]   a_q, b_q, acc_q;
  op_e            opc_q;
  logic           err_cap_q;
  logic [N-1:0]   out_q;
  logic           ovf_q, err_q;
  logic [6:0]     seg_q;

  logic [W-1:0]   res_d, diff;
  logic [W:0]     sum;
  logic           ovf_d;
  logic [3:0]     nib_d;

  onehot_encoder #(.N(N), .W(W)) u_enc_a (.onehot_i(inp1), .bin_o(a_bin), .bad_o(a_bad));
  onehot_encoder #(.N(N), .W(W)) u_enc_b (.onehot_i(inp2), .bin_o(b_bin), .bad_o(b_bad));

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    sum   = '0;
    diff  = a_q - b_q;
    case (opc_q)
      OP_ACC: begin
        sum   = {1'b0, acc_q} + {1'b0, b_q};
        res_d = sum[W-1:0];
        ovf_d = sum[W];
      end
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res_d = sum[W-1:0];
        ovf_d = sum[W];
      end
      // Wrapped difference read as signed, then magnitude; only -2**(W-1) stays negative.
      OP_ABS: begin
        res_d = diff[W-1] ? -diff : diff;
        ovf_d = ABS_SAT & res_d[W-1];
      end
      OP_SMAX: res_d = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
      OP_SMIN: res_d = ($signed(a_q) < $signed(b_q)) ? a_q : b_q;
      OP_UMIN: res_d = (a_q < b_q) ? a_q : b_q;
      OP_UMAX: res_d = (a_q > b_q) ? a_q : b_q;
      default: res_d = b_q;
    endcase
    nib_d = 4'(res_d);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      opc_q     <= OP_ACC;
      err_cap_q <= 1'b0;
      acc_q     <= '0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      seg_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q       <= a_bin;
        b_q       <= b_bin;
        opc_q     <= op_e'(opc);
        err_cap_q <= a_bad | b_bad;
      end
      if (state_q == EXEC) begin
        out_q <= {{(N-1){1'b0}}, 1'b1} << res_d;
        ovf_q <= ovf_d;
        err_q <= err_cap_q;
        seg_q <= SEG_HEX[nib_d];
        if (opc_q == OP_ACC) acc_q <= res_d;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign err       = err_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_onehot_alu_pipe.sv
// Directed bench for onehot_alu_pipe (N=16, ABS_SAT=0) with hand-computed expectations.
module tb_onehot_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] inp1, inp2, out;
  logic [2:0]  opc;
  logic        overflow, err;
  logic [6:0]  seg;

  int n_chk  = 0;
  int n_fail = 0;

  onehot_alu_pipe #(.N(16), .ABS_SAT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inp1(inp1), .inp2(inp2), .opc(opc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .overflow(overflow), .err(err), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op, then confirm the two-cycle accept-to-valid latency.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'd1);
    inp1 = a; inp2 = b; opc = op; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("lat_exec", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_hold", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [15:0] e_out, input logic e_ovf,
                        input logic [6:0] e_seg, input logic e_err);
    issue(a, b, op);
    chk({tag, "/out"}, 32'(out), 32'(e_out));
    chk({tag, "/ovf"}, 32'(overflow), 32'(e_ovf));
    chk({tag, "/seg"}, 32'(seg), 32'(e_seg));
    chk({tag, "/err"}, 32'(err), 32'(e_err));
    release_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    inp1 = '0; inp2 = '0; opc = '0;
    #12;
    chk("rst/in_ready",  32'(in_ready),  32'd1);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/out",       32'(out),       32'd0);
    chk("rst/ovf",       32'(overflow),  32'd0);
    chk("rst/err",       32'(err),       32'd0);
    chk("rst/seg",       32'(seg),       32'd0);
    @(negedge clk); rst = 1'b0;

    // 9+8 = 17 wraps to 1 with carry
    op_chk("add",  16'h1 << 9, 16'h1 << 8, 3'b001, 16'h0002, 1'b1, 7'h06, 1'b0);
    op_chk("abs",  16'h1 << 3, 16'h1 << 10, 3'b010, 16'h1 << 7, 1'b0, 7'h07, 1'b0);
    op_chk("smax", 16'h1 << 3, 16'h1 << 10, 3'b011, 16'h1 << 3, 1'b0, 7'h4F, 1'b0);
    op_chk("smin", 16'h1 << 3, 16'h1 << 10, 3'b100, 16'h1 << 10, 1'b0, 7'h77, 1'b0);
    op_chk("umin", 16'h1 << 3, 16'h1 << 10, 3'b101, 16'h1 << 3, 1'b0, 7'h4F, 1'b0);
    op_chk("umax", 16'h1 << 3, 16'h1 << 10, 3'b110, 16'h1 << 10, 1'b0, 7'h77, 1'b0);

    // accumulator from reset: 5, 10, 15, 20->4
    op_chk("acc1", 16'h1, 16'h1 << 5, 3'b000, 16'h1 << 5,  1'b0, 7'h6D, 1'b0);
    op_chk("acc2", 16'h1, 16'h1 << 5, 3'b000, 16'h1 << 10, 1'b0, 7'h77, 1'b0);
    op_chk("acc3", 16'h1, 16'h1 << 5, 3'b000, 16'h1 << 15, 1'b0, 7'h71, 1'b0);
    op_chk("acc4", 16'h1, 16'h1 << 5, 3'b000, 16'h1 << 4,  1'b1, 7'h66, 1'b0);
    op_chk("pass", 16'h1, 16'h1 << 7, 3'b111, 16'h1 << 7,  1'b0, 7'h07, 1'b0);
    op_chk("acc0", 16'h1, 16'h1,      3'b000, 16'h1 << 4,  1'b0, 7'h66, 1'b0);

    // malformed operands
    op_chk("err_multi", 16'h0011, 16'h1 << 2, 3'b111, 16'h1 << 2, 1'b0, 7'h5B, 1'b1);
    op_chk("err_zero",  16'h0000, 16'h1 << 2, 3'b001, 16'h1 << 2, 1'b0, 7'h5B, 1'b1);

    // back-pressure in HOLD with a pending request
    issue(16'h1 << 1, 16'h1 << 2, 3'b001);
    inp1 = 16'h1; inp2 = 16'h1 << 9; opc = 3'b111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold/out",       32'(out),       32'(16'h1 << 3));
      chk("hold/seg",       32'(seg),       32'h4F);
      chk("hold/in_ready",  32'(in_ready),  32'd0);
      chk("hold/out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("drain/out_valid", 32'(out_valid), 32'd0);
    chk("drain/in_ready",  32'(in_ready),  32'd1);
    chk("drain/out",       32'(out),       32'(16'h1 << 3));
    @(negedge clk);
    in_valid = 1'b0;
    chk("next/in_ready",  32'(in_ready),  32'd0);
    chk("next/out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("next/out_valid1", 32'(out_valid), 32'd1);
    chk("next/out",        32'(out),       32'(16'h1 << 9));
    chk("next/seg",        32'(seg),       32'h6F);
    release_out();

    // reset while an ACC is in EXEC
    @(negedge clk);
    inp1 = 16'h1; inp2 = 16'h1 << 3; opc = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst/out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst/out",       32'(out),       32'd0);
    chk("mid_rst/in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); rst = 1'b0;
    op_chk("acc_after_rst", 16'h1, 16'h1 << 1, 3'b000, 16'h1 << 1, 1'b0, 7'h06, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
